// File: rtl/systolic_seq_2x2.sv
// systolic_seq_2x2: job sequencer for a 2x2 signed 8-bit systolic array.
// Ports: clk/rst (sync, active-high); in_valid/in_ready with a_mat/b_mat job input;
//   arr_clear and arr_a1/a2/b1/b2 drive the array; c11..c22 are its accumulators;
//   out_valid/out_ready with res {C22,C21,C12,C11} as the result; perf_jobs counts completed jobs.
// Optional feature: define SA_SEQ_PERF_EN to build the perf_jobs counter (tied to 0 otherwise).
module systolic_seq_2x2 #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_mat,
  input  logic [31:0] b_mat,
  output logic        arr_clear,
  output logic [7:0]  arr_a1,
  output logic [7:0]  arr_a2,
  output logic [7:0]  arr_b1,
  output logic [7:0]  arr_b2,
  input  logic [17:0] c11,
  input  logic [17:0] c12,
  input  logic [17:0] c21,
  input  logic [17:0] c22,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] res,
  output logic [15:0] perf_jobs
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] beat_q, beat_d;
  logic [3:0] drain_q, drain_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [71:0] res_q, res_d;
  logic clr_q, clr_d;
  logic [7:0] a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic feed, bt0, bt1, bt2;
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    drain_d = drain_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a_mat;
        b_d = b_mat;
        state_d = CLEAR;
      end
      CLEAR: begin
        state_d = FEED;
        beat_d = '0;
      end
      FEED: if (beat_q == 2'd2) begin
        state_d = DRAIN;
        drain_d = '0;
      end else beat_d = beat_q + 2'd1;
      DRAIN: if (drain_q == 4'(DRAIN_CYCLES - 1)) begin
        state_d = DONE;
        res_d = {c22, c21, c12, c11};
      end else drain_d = drain_q + 4'd1;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Operands are computed from the next state so the registered outputs line up with the state they belong to.
  always_comb begin
    feed = state_d == FEED;
    bt0 = feed && beat_d == 2'd0;
    bt1 = feed && beat_d == 2'd1;
    bt2 = feed && beat_d == 2'd2;
    clr_d = state_d == CLEAR;
    a1_d = bt0 ? a_d[7:0] : bt1 ? a_d[15:8] : '0;
    b1_d = bt0 ? b_d[7:0] : bt1 ? b_d[23:16] : '0;
    a2_d = bt1 ? a_d[23:16] : bt2 ? a_d[31:24] : '0;
    b2_d = bt1 ? b_d[15:8] : bt2 ? b_d[31:24] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      drain_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      clr_q <= 1'b0;
      a1_q <= '0;
      a2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      drain_q <= drain_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      clr_q <= clr_d;
      a1_q <= a1_d;
      a2_q <= a2_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign res = res_q;
  assign arr_clear = clr_q;
  assign arr_a1 = a1_q;
  assign arr_a2 = a2_q;
  assign arr_b1 = b1_q;
  assign arr_b2 = b2_q;
`ifdef SA_SEQ_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else if (out_valid && out_ready) perf_q <= perf_q + 16'd1;
  end
  assign perf_jobs = perf_q;
`else
  assign perf_jobs = '0;
`endif
endmodule

// File: tb/tb_systolic_seq_2x2.sv
// tb_systolic_seq_2x2: randomized self-checking bench with a timeline model and a behavioural 2x2 array.
module tb_systolic_seq_2x2;
  localparam int D = 3;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [31:0] a_mat, b_mat;
  logic in_ready, arr_clear, out_valid;
  logic [7:0] arr_a1, arr_a2, arr_b1, arr_b2;
  logic [17:0] c11, c12, c21, c22;
  logic [71:0] res;
  logic [15:0] perf_jobs;
  int n_cmp = 0, n_err = 0;
  bit armed = 0;
  always #5 clk = ~clk;
  systolic_seq_2x2 #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_clear(arr_clear),
    .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_b1(arr_b1), .arr_b2(arr_b2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .perf_jobs(perf_jobs)
  );
  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask
  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction
  // Reference result: plain 2x2 matrix product, truncated to 18 bits per element.
  function automatic logic [71:0] prod(input logic [31:0] a, input logic [31:0] b);
    int x[4], y[4];
    logic [17:0] c[4];
    for (int i = 0; i < 4; i++) begin
      x[i] = sx(a[8*i +: 8]);
      y[i] = sx(b[8*i +: 8]);
    end
    c[0] = 18'(x[0] * y[0] + x[1] * y[2]);
    c[1] = 18'(x[0] * y[1] + x[1] * y[3]);
    c[2] = 18'(x[2] * y[0] + x[3] * y[2]);
    c[3] = 18'(x[2] * y[1] + x[3] * y[3]);
    return {c[3], c[2], c[1], c[0]};
  endfunction
  // Stand-in datapath: output-stationary 2x2 array, A flows right, B flows down.
  int acc[4];
  logic [7:0] ar11, br11, ar21, br12;
  always @(posedge clk) begin
    if (rst || arr_clear) begin
      for (int i = 0; i < 4; i++) acc[i] <= 0;
      ar11 <= '0; br11 <= '0; ar21 <= '0; br12 <= '0;
    end else begin
      acc[0] <= acc[0] + sx(arr_a1) * sx(arr_b1);
      acc[1] <= acc[1] + sx(ar11) * sx(arr_b2);
      acc[2] <= acc[2] + sx(arr_a2) * sx(br11);
      acc[3] <= acc[3] + sx(ar21) * sx(br12);
      ar11 <= arr_a1; br11 <= arr_b1; ar21 <= arr_a2; br12 <= arr_b2;
    end
  end
  assign c11 = acc[0][17:0];
  assign c12 = acc[1][17:0];
  assign c21 = acc[2][17:0];
  assign c22 = acc[3][17:0];
  // Timeline model: ms 0=waiting for a job, 1=busy (mk cycles since acceptance), 2=result held.
  int ms = 0, mk = 0;
  logic [31:0] mA = '0, mB = '0;
  logic [71:0] mres = '0;
  logic [15:0] mperf = '0;
  always @(posedge clk) begin
    if (rst) begin
      ms = 0;
      mperf = '0;
    end else if (ms == 0) begin
      if (in_valid) begin
        mA = a_mat; mB = b_mat; ms = 1; mk = 0;
      end
    end else if (ms == 1) begin
      if (mk == D + 3) begin
        ms = 2;
        mres = prod(mA, mB);
      end else mk++;
    end else if (out_ready) begin
      ms = 0;
`ifdef SA_SEQ_PERF_EN
      mperf = mperf + 16'd1;
`endif
    end
  end
  function automatic logic [31:0] eops();
    if (ms != 1 || mk < 1 || mk > 3) return '0;
    if (mk == 1) return {mA[7:0], 8'h00, mB[7:0], 8'h00};
    if (mk == 2) return {mA[15:8], mA[23:16], mB[23:16], mB[15:8]};
    return {8'h00, mA[31:24], 8'h00, mB[31:24]};
  endfunction
  always @(negedge clk) if (armed) begin
    chk("in_ready", 72'(in_ready), 72'(ms == 0));
    chk("out_valid", 72'(out_valid), 72'(ms == 2));
    chk("arr_clear", 72'(arr_clear), 72'(ms == 1 && mk == 0));
    chk("operands", 72'({arr_a1, arr_a2, arr_b1, arr_b2}), 72'(eops()));
    if (ms == 2) chk("res", res, mres);
    chk("perf_jobs", 72'(perf_jobs), 72'(mperf));
  end
  task automatic reset_checks(input string n);
    chk({n, "_in_ready"}, 72'(in_ready), 72'd1);
    chk({n, "_out_valid"}, 72'(out_valid), 72'd0);
    chk({n, "_res"}, res, 72'd0);
    chk({n, "_clear"}, 72'(arr_clear), 72'd0);
    chk({n, "_ops"}, 72'({arr_a1, arr_a2, arr_b1, arr_b2}), 72'd0);
    chk({n, "_perf"}, 72'(perf_jobs), 72'd0);
  endtask
  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int hold, input bit rst_hs,
                         output logic [71:0] r, output int lat);
    int w, cyc;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_wait", 72'(in_ready), 72'd1);
    in_valid = 1'b1; a_mat = a; b_mat = b; out_ready = hold == 0;
    @(negedge clk);
    in_valid = 1'b0; a_mat = $urandom; b_mat = $urandom;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      cyc++;
    end
    in_valid = 1'b0;
    lat = cyc - 1;
    chk("out_valid_rise", 72'(out_valid), 72'd1);
    r = res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("res_stable", res, r);
      chk("in_ready_busy", 72'(in_ready), 72'd0);
    end
    if (hold > 0) begin out_ready = 1'b1; rst = rst_hs; end
    @(negedge clk);
    rst = 1'b0;
    chk("in_ready_after", 72'(in_ready), 72'd1);
    chk("out_valid_after", 72'(out_valid), 72'd0);
    if (hold > 0 && rst_hs) reset_checks("rst_hs");
  endtask
  logic [71:0] r;
  int lat;
  logic [31:0] ra, rb;
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_mat = '0; b_mat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    armed = 1;
    reset_checks("reset");
    rst = 1'b0;
    chk("model_basic", prod(32'h04030201, 32'h08070605), {18'd50, 18'd43, 18'd22, 18'd19});
    chk("model_signed", prod(32'hFC0302FF, 32'h0807FA05), {18'(-50), 18'(-13), 18'd22, 18'd9});
    chk("model_ext", prod(32'h80808080, 32'h80808080), {4{18'd32768}});
    run_job(32'h04030201, 32'h08070605, 0, 0, r, lat);
    chk("basic_latency", 72'(lat), 72'd7);
    chk("basic_res", r, {18'd50, 18'd43, 18'd22, 18'd19});
    run_job(32'hFC0302FF, 32'h0807FA05, 0, 0, r, lat);
    chk("signed_res", r, {18'(-50), 18'(-13), 18'd22, 18'd9});
    run_job(32'h80808080, 32'h80808080, 5, 0, r, lat);
    chk("ext_res", r, {4{18'd32768}});
    run_job(32'h04030201, 32'h08070605, 0, 0, r, lat);
    chk("b2b_res", r, {18'd50, 18'd43, 18'd22, 18'd19});
    // Abort a job with reset during FEED beat 1.
    in_valid = 1'b1; a_mat = 32'h44332211; b_mat = 32'h88776655;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("beat1_a1", 72'(arr_a1), 72'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_checks("abort");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 72'(out_valid), 72'd0);
    end
    run_job(32'h04030201, 32'h08070605, 0, 0, r, lat);
    chk("after_abort_res", r, {18'd50, 18'd43, 18'd22, 18'd19});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) run_job($urandom, $urandom, i, 0, r, lat);
`ifdef SA_SEQ_PERF_EN
    chk("perf_three", 72'(perf_jobs), 72'd3);
`else
    chk("perf_three", 72'(perf_jobs), 72'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("perf_reset", 72'(perf_jobs), 72'd0);
    run_job(32'h01010101, 32'h01010101, 1, 0, r, lat);
    run_job(32'h7F7F7F7F, 32'h80808080, 2, 1, r, lat);
    chk("rst_hs_perf", 72'(perf_jobs), 72'd0);
    for (int i = 0; i < 25; i++) begin
      ra = $urandom; rb = $urandom;
      run_job(ra, rb, int'($urandom_range(0, 3)), 0, r, lat);
      chk("rand_res", r, prod(ra, rb));
      chk("rand_latency", 72'(lat), 72'(D + 4));
    end
    armed = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
